// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and helpers for the SPI request arbiter
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int CNT_W = 32;

    // Index width for n requesters, never narrower than one bit
    function automatic int ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search starting after the last winner
module rr_picker
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = ID_W(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    // Walk from the farthest candidate to the nearest so the nearest requester after last wins
    always_comb begin
        logic [IW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin sharing of one spi_master between NREQ requesters
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int                 NREQ       = 4,
    parameter int                 NBITS      = 24,
    parameter int                 NCSBITS    = 3,
    parameter logic [NCSBITS-1:0] CS_IDLE    = '1,
    parameter int                 GAP_CYCLES = 4,
    parameter int                 TIMEOUT    = 4096
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*NBITS-1:0]       req_din,
    input  logic [NREQ*NCSBITS-1:0]     req_cs,
    output logic [NREQ-1:0]             grant,
    output logic                        done,
    output logic [ID_W(NREQ)-1:0]       rsp_id,
    output logic [NBITS-1:0]            rsp_dout,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [CNT_W-1:0]            txn_count,
    output logic [CNT_W-1:0]            err_count,
    output logic [NBITS-1:0]            spi_din,
    output logic [NCSBITS-1:0]          spi_cs,
    output logic [NCSBITS-1:0]          spi_cs_idle,
    output logic                        spi_trigger,
    output logic                        spi_ack,
    input  logic [NBITS-1:0]            spi_dout,
    input  logic                        spi_dvld
);

    localparam int IW = ID_W(NREQ);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t             state;
    logic [IW-1:0]      last;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [GW-1:0]      gap_cnt;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [NBITS-1:0]   pick_din;
    logic [NCSBITS-1:0] pick_cs;
    logic [NREQ-1:0]    pick_onehot;
    logic               dvld_new;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A dvld still high in the cycle we are acking is the tail of the previous result
    assign dvld_new = spi_dvld && !spi_ack;

    // Select the winner's word, chip-select code and one-hot grant
    always_comb begin
        pick_din    = '0;
        pick_cs     = '0;
        pick_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_din       = req_din[i*NBITS +: NBITS];
                pick_cs        = req_cs[i*NCSBITS +: NCSBITS];
                pick_onehot[i] = 1'b1;
            end
        end
    end

    // Arbitration FSM with timeout, gap counting and registered responses
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_GAP;
            gap_cnt     <= GW'(GAP_CYCLES);
            tmo_cnt     <= '0;
            last        <= IW'(NREQ - 1);
            grant       <= '0;
            done        <= 1'b0;
            rsp_id      <= '0;
            rsp_dout    <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            txn_count   <= '0;
            err_count   <= '0;
            spi_din     <= '0;
            spi_cs      <= CS_IDLE;
            spi_cs_idle <= CS_IDLE;
            spi_trigger <= 1'b0;
            spi_ack     <= 1'b0;
        end else begin
            grant       <= '0;
            done        <= 1'b0;
            spi_ack     <= 1'b0;
            spi_cs_idle <= CS_IDLE;
            case (state)
                ST_IDLE: begin
                    spi_ack <= dvld_new;
                    if (pick_valid) begin
                        grant       <= pick_onehot;
                        spi_din     <= pick_din;
                        spi_cs      <= pick_cs;
                        spi_trigger <= 1'b1;
                        last        <= pick_idx;
                        tmo_cnt     <= '0;
                        busy        <= 1'b1;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dvld_new) begin
                        rsp_dout    <= spi_dout;
                        rsp_id      <= last;
                        rsp_err     <= 1'b0;
                        done        <= 1'b1;
                        spi_ack     <= 1'b1;
                        spi_trigger <= 1'b0;
                        spi_cs      <= CS_IDLE;
                        txn_count   <= txn_count + 1'b1;
                        gap_cnt     <= GW'(GAP_CYCLES);
                        state       <= ST_GAP;
                    end else if (TIMEOUT != 0 && tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_dout    <= '0;
                        rsp_id      <= last;
                        rsp_err     <= 1'b1;
                        done        <= 1'b1;
                        spi_trigger <= 1'b0;
                        spi_cs      <= CS_IDLE;
                        err_count   <= err_count + 1'b1;
                        gap_cnt     <= GW'(GAP_CYCLES);
                        state       <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    spi_ack <= dvld_new;
                    spi_cs  <= CS_IDLE;
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    gap_cnt <= GW'(GAP_CYCLES);
                    state   <= ST_GAP;
                end
            endcase
        end
    end

endmodule
